// File: rtl/nios_system_sysid_arbiter.sv
// Two-master round-robin read arbiter in front of the zero-wait-state sysid slave.
// Each read takes three cycles: arbitrate (IDLE), accept (ISSUE), return data (RESP).
module nios_system_sysid_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_read,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m1_read,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  s_read,
  output logic [ADDR_WIDTH-1:0] s_address,
  input  logic [DATA_WIDTH-1:0] s_readdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state;
  logic                  grant;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  pick;
  logic                  win_read;

  // m1 wins when alone, or on a tie when m0 was served last.
  assign pick     = m1_read & (~m0_read | ~last_grant);
  assign win_read = grant ? m1_read : m0_read;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr       <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_read | m1_read) begin
            grant <= pick;
            addr  <= pick ? m1_address : m0_address;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // A winner that dropped its read is abandoned without touching fairness.
          if (win_read) begin
            rdata      <= s_readdata;
            last_grant <= grant;
            state      <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign s_read    = (state == ISSUE);
  assign s_address = (state == ISSUE) ? addr : '0;

  assign m0_waitrequest = m0_read & ~((state == ISSUE) & ~grant);
  assign m1_waitrequest = m1_read & ~((state == ISSUE) & grant);

  assign m0_readdatavalid = (state == RESP) & ~grant;
  assign m1_readdatavalid = (state == RESP) & grant;

  assign m0_readdata = rdata;
  assign m1_readdata = rdata;

endmodule

// File: tb/tb_nios_system_sysid_arbiter.sv
// Bench for the sysid read arbiter: directed vector table, fairness/idle sequences,
// then random traffic checked against a transaction-timeline model.
module tb_nios_system_sysid_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_read, m1_read;
  logic [0:0]  m0_address, m1_address;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read;
  logic [0:0]  s_address;
  logic [31:0] s_readdata;
  logic [31:0] id_lo, id_hi;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  assign s_readdata = s_address[0] ? id_hi : id_lo;

  nios_system_sysid_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(1)) dut (
    .clock            (clock),
    .reset            (reset),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_read           (s_read),
    .s_address        (s_address),
    .s_readdata       (s_readdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, r0, a0, r1, a1;
    logic        wr0, wr1, rdv0, rdv1, srd, sad;
    logic [31:0] dat;
  } vec_t;

  localparam logic [31:0] T = 32'h5802B040;
  vec_t tv[25];

  // Timeline model: an arbitration at cycle c means acceptance at c+1, data at c+2.
  int          cyc, acc_c, rsp_c, free_c;
  bit          m_win, m_last;
  logic        m_addr;
  logic [31:0] m_rdata;

  task automatic model_check();
    bit acc;
    acc = (cyc == acc_c);
    chk("s_read", {31'd0, s_read}, {31'd0, acc});
    chk("s_address", {31'd0, s_address}, {31'd0, acc ? m_addr : 1'b0});
    chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, m0_read & ~(acc & (m_win == 1'b0))});
    chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, m1_read & ~(acc & (m_win == 1'b1))});
    chk("m0_readdatavalid", {31'd0, m0_readdatavalid}, {31'd0, (cyc == rsp_c) && !m_win});
    chk("m1_readdatavalid", {31'd0, m1_readdatavalid}, {31'd0, (cyc == rsp_c) && m_win});
    chk("m0_readdata", m0_readdata, m_rdata);
    chk("m1_readdata", m1_readdata, m_rdata);
  endtask

  task automatic model_update();
    if (reset) begin
      acc_c = -1; rsp_c = -1; free_c = cyc + 1; m_last = 1'b1; m_rdata = '0;
    end else if (cyc == acc_c) begin
      if ((m_win ? m1_read : m0_read)) begin
        m_rdata = m_addr ? id_hi : id_lo;
        m_last  = m_win;
        rsp_c   = cyc + 1;
        free_c  = cyc + 2;
      end else begin
        free_c = cyc + 1;
      end
    end else if (cyc >= free_c && (m0_read || m1_read)) begin
      if (m0_read && m1_read) m_win = !m_last;
      else                    m_win = m1_read;
      m_addr = m_win ? m1_address[0] : m0_address[0];
      acc_c  = cyc + 1;
      free_c = 32'h7fff_ffff;
    end
    cyc++;
  endtask

  initial begin
    int          win_cnt [2];
    int          order[$];
    logic [31:0] x;

    id_lo = 32'h0; id_hi = T;
    reset = 1'b1; m0_read = 0; m1_read = 0; m0_address = 0; m1_address = 0;

    //        rst r0 a0 r1 a1  wr0 wr1 v0 v1 srd sad  data
    tv[0]  = '{1, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0,  32'h0};
    tv[1]  = '{0, 1, 1, 0, 0,  1,  0,  0, 0, 0,  0,  32'h0};
    tv[2]  = '{0, 1, 1, 0, 0,  0,  0,  0, 0, 1,  1,  32'h0};
    tv[3]  = '{0, 0, 0, 0, 0,  0,  0,  1, 0, 0,  0,  T};
    tv[4]  = '{1, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0,  T};
    tv[5]  = '{0, 1, 0, 1, 1,  1,  1,  0, 0, 0,  0,  32'h0};
    tv[6]  = '{0, 1, 0, 1, 1,  0,  1,  0, 0, 1,  0,  32'h0};
    tv[7]  = '{0, 0, 0, 1, 1,  0,  1,  1, 0, 0,  0,  32'h0};
    tv[8]  = '{0, 0, 0, 1, 1,  0,  1,  0, 0, 0,  0,  32'h0};
    tv[9]  = '{0, 0, 0, 1, 1,  0,  0,  0, 0, 1,  1,  32'h0};
    tv[10] = '{0, 0, 0, 0, 0,  0,  0,  0, 1, 0,  0,  T};
    tv[11] = '{0, 1, 1, 0, 0,  1,  0,  0, 0, 0,  0,  T};
    tv[12] = '{0, 1, 1, 0, 0,  0,  0,  0, 0, 1,  1,  T};
    tv[13] = '{0, 0, 0, 0, 0,  0,  0,  1, 0, 0,  0,  T};
    tv[14] = '{0, 0, 0, 1, 0,  0,  1,  0, 0, 0,  0,  T};
    tv[15] = '{0, 0, 0, 0, 0,  0,  0,  0, 0, 1,  0,  T};
    tv[16] = '{0, 1, 0, 1, 1,  1,  1,  0, 0, 0,  0,  T};
    tv[17] = '{0, 1, 0, 1, 1,  1,  0,  0, 0, 1,  1,  T};
    tv[18] = '{0, 1, 0, 0, 0,  1,  0,  0, 1, 0,  0,  T};
    tv[19] = '{0, 1, 0, 0, 0,  1,  0,  0, 0, 0,  0,  T};
    tv[20] = '{1, 1, 0, 0, 0,  0,  0,  0, 0, 1,  0,  T};
    tv[21] = '{0, 1, 0, 1, 1,  1,  1,  0, 0, 0,  0,  32'h0};
    tv[22] = '{0, 1, 0, 1, 1,  0,  1,  0, 0, 1,  0,  32'h0};
    tv[23] = '{0, 0, 0, 1, 1,  0,  1,  1, 0, 0,  0,  32'h0};
    tv[24] = '{0, 0, 0, 0, 0,  0,  0,  0, 0, 0,  0,  32'h0};

    for (int i = 0; i < 25; i++) begin
      reset = tv[i].rst; m0_read = tv[i].r0; m0_address = tv[i].a0;
      m1_read = tv[i].r1; m1_address = tv[i].a1;
      @(negedge clock);
      chk($sformatf("v%0d.m0_waitrequest", i), {31'd0, m0_waitrequest}, {31'd0, tv[i].wr0});
      chk($sformatf("v%0d.m1_waitrequest", i), {31'd0, m1_waitrequest}, {31'd0, tv[i].wr1});
      chk($sformatf("v%0d.m0_readdatavalid", i), {31'd0, m0_readdatavalid}, {31'd0, tv[i].rdv0});
      chk($sformatf("v%0d.m1_readdatavalid", i), {31'd0, m1_readdatavalid}, {31'd0, tv[i].rdv1});
      chk($sformatf("v%0d.s_read", i), {31'd0, s_read}, {31'd0, tv[i].srd});
      chk($sformatf("v%0d.s_address", i), {31'd0, s_address}, {31'd0, tv[i].sad});
      chk($sformatf("v%0d.m0_readdata", i), m0_readdata, tv[i].dat);
      chk($sformatf("v%0d.m1_readdata", i), m1_readdata, tv[i].dat);
      @(posedge clock); #1;
    end

    // Fairness: both masters hold read for 12 cycles; m0 was served last.
    win_cnt[0] = 0; win_cnt[1] = 0;
    m0_read = 1; m1_read = 1; m0_address = 0; m1_address = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("fair.no_overlap", {31'd0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
      if (m0_readdatavalid) begin win_cnt[0]++; order.push_back(0); end
      if (m1_readdatavalid) begin win_cnt[1]++; order.push_back(1); end
      @(posedge clock); #1;
    end
    m0_read = 0; m1_read = 0;
    chk("fair.pulses", order.size(), 4);
    chk("fair.m0_count", win_cnt[0], 2);
    chk("fair.m1_count", win_cnt[1], 2);
    if (order.size() > 0) chk("fair.first_m1", order[0], 1);
    for (int i = 1; i < order.size(); i++) chk("fair.alternate", order[i], 1 - order[i-1]);

    // Idle stability.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      x = {27'd0, s_read, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid};
      chk("idle.quiet", x, 32'd0);
      @(posedge clock); #1;
    end

    // Random traffic against the timeline model, starting from a reset.
    cyc = 0; acc_c = -1; rsp_c = -1; free_c = 0; m_last = 1'b1; m_win = 1'b0;
    m_addr = 1'b0; m_rdata = '0;
    reset = 1;
    @(posedge clock); #1;
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      m0_read    = ($urandom_range(0, 3) != 0);
      m1_read    = ($urandom_range(0, 3) != 0);
      m0_address = 1'($urandom_range(0, 1));
      m1_address = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin id_lo = $urandom; id_hi = $urandom; end
      @(negedge clock);
      model_check();
      @(posedge clock);
      model_update();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_arbiter.md
# nios_system_sysid_arbiter

Two-master round-robin read arbiter that shares the single read-only system-ID control slave (zero-wait-state, combinational readdata, address 0 = ID, address 1 = timestamp) between two Avalon-MM read masters. It sits between the masters (e.g. CPU data master and a boot/debug master) and the sysid slave. It serialises their reads, registers the returned word, and presents it with readdatavalid to the winning master.

## Interface
- DATA_WIDTH, 32, readdata width on every port
- ADDR_WIDTH, 1, word address width on every port
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- m0_read  input  1  master 0 read request; held until accepted
- m0_address  input  ADDR_WIDTH  master 0 word address
- m0_waitrequest  output  1  master 0 stall
- m0_readdata  output  DATA_WIDTH  master 0 returned data
- m0_readdatavalid  output  1  master 0 data strobe, one cycle
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0, for master 1
- s_read  output  1  read strobe to sysid slave
- s_address  output  ADDR_WIDTH  address to sysid slave
- s_readdata  input  DATA_WIDTH  combinational slave data

## Operation
- State machine, three states:
  - IDLE: arbitrate among asserted mN_read.
    - One requester: that master wins.
    - Both: master != last_grant wins.
    - Latch grant and winner's address; go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE:
    - s_read=1, s_address=latched address.
    - Winner's waitrequest=0; the transaction is accepted this cycle.
    - rdata register <= s_readdata; last_grant <= grant; go to RESP.
    - If winner's read is low in ISSUE (protocol violation): abort, no readdatavalid, last_grant unchanged, return to IDLE.
  - RESP:
    - Winner's readdatavalid=1, readdata=rdata; go to IDLE.
- Waitrequest rules:
  - mN_waitrequest = mN_read AND NOT (state==ISSUE AND grant==N).
  - The loser is stalled throughout and is served in the next arbitration.
- Output values outside strobes:
  - mN_readdata = rdata for both masters at all times; only meaningful with readdatavalid.
  - s_read=0 and s_address=0 outside ISSUE.
  - Each readdatavalid is low except in RESP for the granted master.
- Address is passed through unmodified; no width conversion.
- Reset values: state=IDLE, last_grant=1 (master 0 wins the first tie), grant=0, rdata=0, all outputs 0.
  - Waitrequest follows mN_read combinationally, even in reset.
- Reset asserted mid-transaction (ISSUE or RESP): next cycle is IDLE, any pending readdatavalid is dropped, rdata=0.

## Timing
- Request first seen at cycle t (IDLE) -> accepted (waitrequest low) at t+1 -> readdatavalid at t+2.
- Latency: 2 cycles from request to data.
- Throughput: one read per 3 cycles.
- Back-to-back: a master holding read continuously gets one read per 3 cycles if alone; with both masters active, grants alternate: m0, m1, m0, ...
- A request arriving in ISSUE or RESP is sampled in the following IDLE cycle.
- No combinational path from mN_read to s_read. The only combinational outputs are the waitrequests.

## Test plan
- Reset then single read: m0_read=1, m0_address=1, slave model returns 0x5802B040 for addr 1 and 0x00000000 for addr 0 -> m0_waitrequest low at t+1, m0_readdatavalid=1 with 0x5802B040 at t+2, m1 outputs idle.
- Simultaneous requests after reset: m0 addr 0, m1 addr 1 -> m0 served first (data 0x00000000 at t+2), m1 accepted at t+4, data 0x5802B040 at t+5; m1_waitrequest high t..t+3.
- Fairness: both masters hold read for 12 cycles -> grants strictly alternate m0, m1, m0, m1; 4 readdatavalid pulses total, 2 per master, none overlapping.
- Abort: m1 requests at t, deasserts m1_read at t+1 (ISSUE) -> no m1_readdatavalid, state IDLE at t+2; next tie still favours m1 (last_grant unchanged).
- Reset mid-operation: reset asserted in ISSUE cycle -> no readdatavalid on either master, all outputs 0 next cycle, next tie goes to m0.
- Idle stability: no requests for 20 cycles -> s_read, both waitrequests and both readdatavalids remain 0.
